// File: rtl/cdb_arbiter.sv
// Round-robin arbiter plus output register for the common data bus; one winner per cycle.
// Optional statistics counters (bcast_cnt, confl_cnt) are built when CDB_STATS_EN is defined.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int UNIT_SIZE = 8,
    parameter int WORD_SIZE = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UNIT_SIZE-1:0]   req_tag,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           cdb_stall,
    input  logic                           flush,
    output logic                           cdb_valid,
    output logic [UNIT_SIZE-1:0]           cdb_tag,
    output logic [WORD_SIZE-1:0]           cdb_data
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]                    bcast_cnt,
    output logic [31:0]                    confl_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic             found;
    logic             grant_en;
    logic             grant;
    logic             xfer;

    // Output register may accept a new winner when it is empty or being drained this cycle.
    assign grant_en = !rst && !flush && (!cdb_valid || !cdb_stall);
    assign grant    = grant_en && found;
    assign xfer     = cdb_valid && !cdb_stall;

    // Scan starts at rr_ptr and wraps; depends only on req_valid, never on tag/data.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= req_tag[winner*UNIT_SIZE +: UNIT_SIZE];
            cdb_data  <= req_data[winner*WORD_SIZE +: WORD_SIZE];
            rr_ptr    <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end else if (!cdb_valid || !cdb_stall) begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_cnt <= '0;
            confl_cnt <= '0;
        end else begin
            if (xfer) bcast_cnt <= bcast_cnt + 32'd1;
            if (grant_en && ($countones(req_valid) >= 2)) confl_cnt <= confl_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations (4 units, 8-bit tag, 32-bit data).
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [31:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdb_stall;
    logic         flush;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic [31:0]  cdb_data;
`ifdef CDB_STATS_EN
    logic [31:0]  bcast_cnt;
    logic [31:0]  confl_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tags  [4];
    logic [31:0] datas [4];

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(4), .UNIT_SIZE(8), .WORD_SIZE(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_stall (cdb_stall),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
`ifdef CDB_STATS_EN
        ,
        .bcast_cnt (bcast_cnt),
        .confl_cnt (confl_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_units();
        req_tag  = {tags[3], tags[2], tags[1], tags[0]};
        req_data = {datas[3], datas[2], datas[1], datas[0]};
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tags[i]  = 8'h20 + 8'(i);
            datas[i] = 32'h1000_0000 + 32'(i);
        end
        load_units();
        rst       = 1'b1;
        req_valid = 4'hF;
        cdb_stall = 1'b0;
        flush     = 1'b0;

        // Test 1: reset with all units requesting
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(cdb_valid), 32'h0);
        chk("rst_tag",   32'(cdb_tag),   32'h0);
        chk("rst_data",  cdb_data,       32'h0);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        tick();
        chk("first_bcast_valid", 32'(cdb_valid), 32'h1);
        chk("first_bcast_tag",   32'(cdb_tag),   32'h20);

        // Test 2: lone request from unit 2
        tags[2]   = 8'h41;
        datas[2]  = 32'hDEADBEEF;
        load_units();
        req_valid = 4'b0100;
        #1;
        chk("u2_ready", 32'(req_ready), 32'h4);
        tick();
        chk("u2_valid", 32'(cdb_valid), 32'h1);
        chk("u2_tag",   32'(cdb_tag),   32'h41);
        chk("u2_data",  cdb_data,       32'hDEADBEEF);
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(req_ready), 32'h0);
        tick();
        chk("u2_drop_valid", 32'(cdb_valid), 32'h0);
        chk("u2_hold_tag",   32'(cdb_tag),   32'h41);

        // Test 3: mid-operation reset, then all units requesting continuously
        tags[2]  = 8'h22;
        datas[2] = 32'h1000_0002;
        load_units();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 1) begin
                chk("rr_valid", 32'(cdb_valid), 32'h1);
                chk("rr_tag",   32'(cdb_tag),   32'(tags[(k - 1) % 4]));
                chk("rr_data",  cdb_data,       datas[(k - 1) % 4]);
            end
            tick();
        end
        chk("rr_last_tag", 32'(cdb_tag), 32'h20);

        // Test 4: stall for 3 cycles while broadcasting unit 0
        cdb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk("stall_valid", 32'(cdb_valid), 32'h1);
            chk("stall_tag",   32'(cdb_tag),   32'h20);
            tick();
        end
        cdb_stall = 1'b0;
        #1;
        chk("unstall_grant", 32'(req_ready), 32'h2);
        tick();
        chk("unstall_valid", 32'(cdb_valid), 32'h1);
        chk("unstall_tag",   32'(cdb_tag),   32'h21);

        // Test 5: flush during stall
        cdb_stall = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_ready", 32'(req_ready), 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_valid", 32'(cdb_valid), 32'h0);
        chk("flush_ptr_kept", 32'(req_ready), 32'h4);
        cdb_stall = 1'b0;
        tick();
        chk("post_flush_tag", 32'(cdb_tag), 32'h22);

`ifdef CDB_STATS_EN
        // Test 6: statistics over 8 cycles of full contention
        rst = 1'b1;
        tick();
        chk("stat_rst_bcast", bcast_cnt, 32'h0);
        chk("stat_rst_confl", confl_cnt, 32'h0);
        rst       = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) tick();
        chk("stat_bcast", bcast_cnt, 32'd7);
        chk("stat_confl", confl_cnt, 32'd8);
`endif

        req_valid = 4'h0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
